// File: rtl/snd_cmd_latch.sv
// snd_cmd_latch: 68000 -> Z80 sound command mailbox in the clk_main domain.
// The 68000 writes a byte on the falling edge of SNDDT and requests a Z80 interrupt with
// a rising edge on SNDON. The Z80 reads through its latch select and acknowledges the
// interrupt with an M1/IORQ cycle.
// Build option: define SNDLATCH_FIFO_EN for a 2^DEPTH_LOG2-entry FIFO. Without it, the
// storage is a single overwrite register.
module snd_cmd_latch #(
  parameter int unsigned DEPTH_LOG2 = 2
) (
  input  logic       clk_main,
  input  logic       nRESET,
  input  logic       SNDDT,
  input  logic       SNDON,
  input  logic [7:0] m68k_dout_lo,
  input  logic       z80_ce,
  input  logic       z80_nCS,
  input  logic       z80_nRD,
  input  logic       z80_nM1,
  input  logic       z80_nIORQ,
  output logic [7:0] z80_dout,
  output logic       z80_nINT,
  output logic       pending,
  output logic       overrun
);

  typedef enum logic [1:0] {StIdle, StReq, StAck} irq_state_e;

  logic       snddt_q, sndon_q;
  logic       rd_active_q, rd_active_d;
  logic       rd_idle_q, rd_idle_d;
  logic       wr_ev, rd_now, pop_ev, sndon_rise;
  logic       pending_q, pending_d;
  logic       overrun_q, overrun_d;
  irq_state_e state_q, state_d;
  logic       rearm_q, rearm_d;
  logic       nint_q, nint_d;

  assign wr_ev      = !SNDDT && snddt_q;
  assign sndon_rise = SNDON && !sndon_q;
  assign rd_now     = !z80_nCS && !z80_nRD;
  // The pop happens when the read ends, so the data stays stable for the whole read.
  assign pop_ev     = z80_ce && !rd_now && rd_active_q;

  // Read tracking. A read counts only if it began after an idle sample. This stops a
  // read that was already in progress across reset from popping anything.
  always_comb begin
    rd_active_d = rd_active_q;
    rd_idle_d   = rd_idle_q;
    if (z80_ce) begin
      rd_idle_d = !rd_now;
      if (rd_now) begin
        rd_active_d = rd_active_q | rd_idle_q;
      end else begin
        rd_active_d = 1'b0;
      end
    end
  end

  // Edge-detect and read-tracking registers.
  always_ff @(posedge clk_main or negedge nRESET) begin
    if (!nRESET) begin
      snddt_q     <= 1'b1;
      sndon_q     <= 1'b0;
      rd_active_q <= 1'b0;
      rd_idle_q   <= 1'b0;
    end else begin
      snddt_q     <= SNDDT;
      sndon_q     <= SNDON;
      rd_active_q <= rd_active_d;
      rd_idle_q   <= rd_idle_d;
    end
  end

`ifdef SNDLATCH_FIFO_EN
  localparam int unsigned Depth = 1 << DEPTH_LOG2;

  logic [7:0]            mem_q [Depth];
  logic [7:0]            mem_d [Depth];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   cnt_q, cnt_d;
  logic [7:0]            last_q, last_d;
  logic                  empty, full, do_pop, do_wr;

  assign empty  = (cnt_q == '0);
  assign full   = cnt_q[DEPTH_LOG2];
  assign do_pop = pop_ev && !empty;
  // A pop in the same cycle frees a slot, so a write to a full FIFO is kept.
  assign do_wr  = wr_ev && (!full || do_pop);

  // FIFO next state: pointers wrap naturally at the power-of-two depth.
  always_comb begin
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    overrun_d = overrun_q | (wr_ev && !do_wr);
    if (do_wr) begin
      mem_d[wr_ptr_q] = m68k_dout_lo;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      last_d   = mem_q[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (do_wr && !do_pop) begin
      cnt_d = cnt_q + 1'b1;
    end else if (!do_wr && do_pop) begin
      cnt_d = cnt_q - 1'b1;
    end
    pending_d = (cnt_d != '0);
  end

  // FIFO storage registers.
  always_ff @(posedge clk_main or negedge nRESET) begin
    if (!nRESET) begin
      mem_q    <= '{default: 8'h00};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      last_q   <= 8'h00;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
    end
  end

  // Show the head entry. Once the FIFO drains, show the byte that was popped last.
  assign z80_dout = empty ? last_q : mem_q[rd_ptr_q];
`else
  logic [7:0] data_q, data_d;
  logic       unused_depth;

  assign unused_depth = ^DEPTH_LOG2;

  // Single register: a write always overwrites. A pop clears pending but keeps the data.
  always_comb begin
    data_d    = data_q;
    pending_d = pending_q;
    overrun_d = overrun_q | (wr_ev && pending_q && !pop_ev);
    if (pop_ev) begin
      pending_d = 1'b0;
    end
    if (wr_ev) begin
      data_d    = m68k_dout_lo;
      pending_d = 1'b1;
    end
  end

  // Data register.
  always_ff @(posedge clk_main or negedge nRESET) begin
    if (!nRESET) begin
      data_q <= 8'h00;
    end else begin
      data_q <= data_d;
    end
  end

  assign z80_dout = data_q;
`endif

  // IRQ next state. SNDON edges in REQ are merged; an edge seen in ACK re-arms.
  always_comb begin
    state_d = state_q;
    rearm_d = rearm_q;
    unique case (state_q)
      StIdle: begin
        if (sndon_rise) state_d = StReq;
      end
      StReq: begin
        if (z80_ce && !z80_nM1 && !z80_nIORQ) state_d = StAck;
      end
      StAck: begin
        if (sndon_rise) rearm_d = 1'b1;
        if (z80_ce && z80_nIORQ) begin
          state_d = (rearm_q || sndon_rise) ? StReq : StIdle;
          rearm_d = 1'b0;
        end
      end
      default: begin
        state_d = StIdle;
        rearm_d = 1'b0;
      end
    endcase
    nint_d = (state_d != StReq);
  end

  // IRQ state and registered outputs.
  always_ff @(posedge clk_main or negedge nRESET) begin
    if (!nRESET) begin
      state_q   <= StIdle;
      rearm_q   <= 1'b0;
      nint_q    <= 1'b1;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rearm_q   <= rearm_d;
      nint_q    <= nint_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
    end
  end

  assign z80_nINT = nint_q;
  assign pending  = pending_q;
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_snd_cmd_latch.sv
// Testbench for snd_cmd_latch. It runs a cycle-by-cycle vector table (write, read, IRQ)
// and then directed sequences for build depth, same-cycle write/pop and async reset.
module tb_snd_cmd_latch;

  logic       clk_main = 1'b0;
  logic       nRESET = 1'b0;
  logic       SNDDT = 1'b1;
  logic       SNDON = 1'b0;
  logic [7:0] m68k_dout_lo = 8'h00;
  logic       z80_ce = 1'b1;
  logic       z80_nCS = 1'b1;
  logic       z80_nRD = 1'b1;
  logic       z80_nM1 = 1'b1;
  logic       z80_nIORQ = 1'b1;
  logic [7:0] z80_dout;
  logic       z80_nINT, pending, overrun;

  int n_checks = 0;
  int n_fail = 0;

  snd_cmd_latch #(.DEPTH_LOG2(2)) dut (
    .clk_main     (clk_main),
    .nRESET       (nRESET),
    .SNDDT        (SNDDT),
    .SNDON        (SNDON),
    .m68k_dout_lo (m68k_dout_lo),
    .z80_ce       (z80_ce),
    .z80_nCS      (z80_nCS),
    .z80_nRD      (z80_nRD),
    .z80_nM1      (z80_nM1),
    .z80_nIORQ    (z80_nIORQ),
    .z80_dout     (z80_dout),
    .z80_nINT     (z80_nINT),
    .pending      (pending),
    .overrun      (overrun)
  );

  always #5 clk_main = ~clk_main;

  typedef struct {
    logic       snddt, sndon;
    logic [7:0] din;
    logic       ce, ncs, nrd, nm1, niorq;
    logic [7:0] dout;
    logic       nint, pend, ov;
  } vec_t;

  vec_t tbl [32];

  function automatic vec_t mk(input logic snddt, input logic sndon, input logic [7:0] din,
                              input logic ce, input logic ncs, input logic nrd,
                              input logic nm1, input logic niorq, input logic [7:0] dout,
                              input logic nint, input logic pend, input logic ov);
    vec_t v;
    v.snddt = snddt; v.sndon = sndon; v.din = din; v.ce = ce; v.ncs = ncs; v.nrd = nrd;
    v.nm1 = nm1; v.niorq = niorq; v.dout = dout; v.nint = nint; v.pend = pend; v.ov = ov;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    SNDDT = 1'b1; z80_ce = 1'b1; z80_nCS = 1'b1; z80_nRD = 1'b1;
    z80_nM1 = 1'b1; z80_nIORQ = 1'b1;
  endtask

  task automatic reset_dut();
    @(negedge clk_main);
    nRESET = 1'b0;
    SNDON = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk_main);
    nRESET = 1'b1;
    repeat (2) @(posedge clk_main);
    #1;
  endtask

  task automatic write_byte(input logic [7:0] b);
    @(negedge clk_main);
    SNDDT = 1'b0;
    m68k_dout_lo = b;
    @(negedge clk_main);
    SNDDT = 1'b1;
    @(posedge clk_main);
    #1;
  endtask

  // Two active Z80 samples, then release. The data must hold across the whole read.
  task automatic z80_read(input string nm, input logic [7:0] exp);
    @(negedge clk_main);
    z80_nCS = 1'b0; z80_nRD = 1'b0;
    @(posedge clk_main); #1;
    chk({nm, " d0"}, z80_dout, exp);
    @(posedge clk_main); #1;
    chk({nm, " d1"}, z80_dout, exp);
    @(negedge clk_main);
    z80_nCS = 1'b1; z80_nRD = 1'b1;
    @(posedge clk_main); #1;
  endtask

  initial begin
    //              snddt sndon din  ce ncs nrd nm1 niorq  dout  nint pend ov
    tbl[0]  = mk(1, 0, 8'h3C, 1, 1, 1, 1, 1, 8'h00, 1, 0, 0);
    tbl[1]  = mk(0, 0, 8'h3C, 1, 1, 1, 1, 1, 8'h3C, 1, 1, 0);
    tbl[2]  = mk(0, 0, 8'h99, 1, 1, 1, 1, 1, 8'h3C, 1, 1, 0);
    tbl[3]  = mk(0, 0, 8'h99, 1, 1, 1, 1, 1, 8'h3C, 1, 1, 0);
    tbl[4]  = mk(0, 0, 8'h99, 1, 1, 1, 1, 1, 8'h3C, 1, 1, 0);
    tbl[5]  = mk(0, 0, 8'h99, 1, 1, 1, 1, 1, 8'h3C, 1, 1, 0);
    tbl[6]  = mk(1, 0, 8'h99, 1, 1, 1, 1, 1, 8'h3C, 1, 1, 0);
    tbl[7]  = mk(1, 0, 8'h99, 1, 0, 0, 1, 1, 8'h3C, 1, 1, 0);
    tbl[8]  = mk(1, 0, 8'h99, 0, 0, 0, 1, 1, 8'h3C, 1, 1, 0);
    tbl[9]  = mk(1, 0, 8'h99, 1, 0, 0, 1, 1, 8'h3C, 1, 1, 0);
    tbl[10] = mk(1, 0, 8'h99, 0, 1, 1, 1, 1, 8'h3C, 1, 1, 0);
    tbl[11] = mk(1, 0, 8'h99, 1, 1, 1, 1, 1, 8'h3C, 1, 0, 0);
    tbl[12] = mk(1, 0, 8'h99, 1, 1, 1, 1, 1, 8'h3C, 1, 0, 0);
    tbl[13] = mk(1, 1, 8'h99, 1, 1, 1, 1, 1, 8'h3C, 0, 0, 0);
    tbl[14] = mk(1, 1, 8'h99, 1, 1, 1, 1, 1, 8'h3C, 0, 0, 0);
    tbl[15] = mk(1, 0, 8'h99, 1, 1, 1, 1, 1, 8'h3C, 0, 0, 0);
    tbl[16] = mk(1, 1, 8'h99, 1, 1, 1, 1, 1, 8'h3C, 0, 0, 0);
    tbl[17] = mk(1, 1, 8'h99, 0, 1, 1, 0, 0, 8'h3C, 0, 0, 0);
    tbl[18] = mk(1, 1, 8'h99, 1, 1, 1, 0, 0, 8'h3C, 1, 0, 0);
    tbl[19] = mk(1, 0, 8'h99, 1, 1, 1, 0, 0, 8'h3C, 1, 0, 0);
    tbl[20] = mk(1, 1, 8'h99, 1, 1, 1, 1, 0, 8'h3C, 1, 0, 0);
    tbl[21] = mk(1, 1, 8'h99, 0, 1, 1, 1, 1, 8'h3C, 1, 0, 0);
    tbl[22] = mk(1, 1, 8'h99, 1, 1, 1, 1, 1, 8'h3C, 0, 0, 0);
    tbl[23] = mk(1, 1, 8'h99, 1, 1, 1, 1, 1, 8'h3C, 0, 0, 0);
    tbl[24] = mk(1, 1, 8'h99, 1, 1, 1, 0, 0, 8'h3C, 1, 0, 0);
    tbl[25] = mk(1, 1, 8'h99, 1, 1, 1, 1, 1, 8'h3C, 1, 0, 0);
    tbl[26] = mk(1, 0, 8'h99, 1, 1, 1, 1, 1, 8'h3C, 1, 0, 0);
    tbl[27] = mk(1, 1, 8'h99, 1, 1, 1, 1, 1, 8'h3C, 0, 0, 0);
    tbl[28] = mk(1, 1, 8'h99, 1, 1, 1, 0, 0, 8'h3C, 1, 0, 0);
    tbl[29] = mk(1, 1, 8'h99, 1, 1, 1, 1, 1, 8'h3C, 1, 0, 0);
    tbl[30] = mk(1, 1, 8'h99, 1, 0, 0, 1, 1, 8'h3C, 1, 0, 0);
    tbl[31] = mk(1, 1, 8'h99, 1, 1, 1, 1, 1, 8'h3C, 1, 0, 0);

    reset_dut();
    chk("reset dout", z80_dout, 8'h00);
    chk("reset nint", {7'b0, z80_nINT}, 8'h01);
    chk("reset pending", {7'b0, pending}, 8'h00);
    chk("reset overrun", {7'b0, overrun}, 8'h00);

    for (int i = 0; i < 32; i++) begin
      @(negedge clk_main);
      SNDDT = tbl[i].snddt; SNDON = tbl[i].sndon; m68k_dout_lo = tbl[i].din;
      z80_ce = tbl[i].ce; z80_nCS = tbl[i].ncs; z80_nRD = tbl[i].nrd;
      z80_nM1 = tbl[i].nm1; z80_nIORQ = tbl[i].niorq;
      @(posedge clk_main); #1;
      chk($sformatf("vec%0d dout", i), z80_dout, tbl[i].dout);
      chk($sformatf("vec%0d nint", i), {7'b0, z80_nINT}, {7'b0, tbl[i].nint});
      chk($sformatf("vec%0d pending", i), {7'b0, pending}, {7'b0, tbl[i].pend});
      chk($sformatf("vec%0d overrun", i), {7'b0, overrun}, {7'b0, tbl[i].ov});
    end

    // Fill beyond capacity, then drain.
    reset_dut();
`ifdef SNDLATCH_FIFO_EN
    for (int i = 1; i <= 5; i++) write_byte(8'(i));
    chk("fifo overrun", {7'b0, overrun}, 8'h01);
    chk("fifo head", z80_dout, 8'h01);
    for (int i = 1; i <= 4; i++) begin
      z80_read($sformatf("fifo rd%0d", i), 8'(i));
      chk($sformatf("fifo pend%0d", i), {7'b0, pending}, (i < 4) ? 8'h01 : 8'h00);
    end
    z80_read("fifo rd5 empty", 8'h04);
    chk("fifo pend5", {7'b0, pending}, 8'h00);
    chk("fifo dout5", z80_dout, 8'h04);
`else
    write_byte(8'hAA);
    chk("single ov0", {7'b0, overrun}, 8'h00);
    write_byte(8'h55);
    chk("single ov1", {7'b0, overrun}, 8'h01);
    z80_read("single rd", 8'h55);
    chk("single pend", {7'b0, pending}, 8'h00);
    chk("single keep", z80_dout, 8'h55);
`endif

    // Write and pop land on the same edge.
    reset_dut();
    write_byte(8'h11);
    @(negedge clk_main);
    z80_nCS = 1'b0; z80_nRD = 1'b0;
    @(negedge clk_main);
    z80_nCS = 1'b1; z80_nRD = 1'b1;
    SNDDT = 1'b0; m68k_dout_lo = 8'h22;
    @(posedge clk_main); #1;
    chk("wrpop dout", z80_dout, 8'h22);
    chk("wrpop pending", {7'b0, pending}, 8'h01);
    chk("wrpop overrun", {7'b0, overrun}, 8'h00);
    @(negedge clk_main);
    SNDDT = 1'b1;

    // Asynchronous reset during a read with an interrupt pending.
    reset_dut();
    write_byte(8'h5A);
    @(negedge clk_main);
    SNDON = 1'b1;
    @(posedge clk_main); #1;
    chk("ar nint req", {7'b0, z80_nINT}, 8'h00);
    @(negedge clk_main);
    z80_nCS = 1'b0; z80_nRD = 1'b0;
    @(posedge clk_main); #1;
    chk("ar pre dout", z80_dout, 8'h5A);
    #2;
    nRESET = 1'b0;
    SNDON = 1'b0;
    #1;
    chk("ar dout", z80_dout, 8'h00);
    chk("ar nint", {7'b0, z80_nINT}, 8'h01);
    chk("ar pending", {7'b0, pending}, 8'h00);
    repeat (2) @(negedge clk_main);
    nRESET = 1'b1;
    @(posedge clk_main); #1;
    write_byte(8'h6B);
    chk("ar post pend", {7'b0, pending}, 8'h01);
    @(negedge clk_main);
    z80_nCS = 1'b1; z80_nRD = 1'b1;
    @(posedge clk_main); #1;
    chk("ar no pop", {7'b0, pending}, 8'h01);
    chk("ar dout2", z80_dout, 8'h6B);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/snd_cmd_latch.md
# snd_cmd_latch

Sound command mailbox between the 68000 and the Z80 sound subsystem, running in the `clk_main` domain.
- 68000 side: writes a command byte through the `SNDDT` decode strobe and raises the Z80 interrupt through the `SNDON` output bit.
- Z80 side: reads the byte through its latch select and acknowledges the interrupt with an M1/IORQ cycle.
- The block is the receiving end of the 68000 sound-command path and sits between the CPU address decode and the Z80 data-in mux.

## Interface
Parameters:
- `DEPTH_LOG2`, default 2: log2 of the FIFO depth. Used only when `SNDLATCH_FIFO_EN` is defined.

Ports:
- `clk_main`  in  1  main clock. All state is clocked on its rising edge.
- `nRESET`  in  1  reset, asynchronous, active-low.
- `SNDDT`  in  1  active-low 68000 write strobe from the I/O decoder.
- `SNDON`  in  1  68000 sound-IRQ control bit, level.
- `m68k_dout_lo`  in  8  68000 data bus bits [7:0].
- `z80_ce`  in  1  Z80 clock enable, nominally 3.58 MHz. All Z80-side sampling is qualified by it.
- `z80_nCS`  in  1  active-low latch select from the Z80 decoder.
- `z80_nRD`  in  1  Z80 read strobe, active-low.
- `z80_nM1`  in  1  Z80 M1, active-low.
- `z80_nIORQ`  in  1  Z80 IORQ, active-low.
- `z80_dout`  out  8  latch data presented to the Z80 data-in mux.
- `z80_nINT`  out  1  Z80 interrupt request, active-low.
- `pending`  out  1  unread data present.
- `overrun`  out  1  sticky: a write was lost or a pending byte was overwritten.

## Operation
Reset values:
- `z80_dout`=0x00, `z80_nINT`=1, `pending`=0, `overrun`=0.
- IRQ state = IDLE; all edge-detect registers = 1 for strobes and 0 for `SNDON`.

68000 write:
- The write event is the cycle where `SNDDT`=0 and its previous sample was 1.
- On that edge, `m68k_dout_lo` is captured.
- Holding `SNDDT` low produces one write only.

Z80 read:
- A read is in progress while `z80_ce` samples `z80_nCS`=0 and `z80_nRD`=0.
- The pop event is the first `z80_ce` sample with the read deasserted after at least one active sample. Data therefore stays stable for the whole read cycle.
- `z80_dout` always shows the head entry. When empty, it shows the last popped value.

IRQ state machine:
- IDLE: a `SNDON` 0→1 edge moves to REQ.
- REQ: `z80_nINT`=0. A `z80_ce` sample with `z80_nM1`=0 and `z80_nIORQ`=0 moves to ACK.
- ACK: `z80_nINT`=1. A `z80_ce` sample with `z80_nIORQ`=1 moves to IDLE, or to REQ if `rearm` is set; `rearm` is cleared on leaving ACK.
- A `SNDON` rising edge in REQ is merged (ignored).
- A `SNDON` rising edge in ACK sets `rearm`.
- The IRQ is independent of data state; the Z80 may read without an interrupt.

Boundary cases:
- Write and pop in the same cycle: both are performed.
    - FIFO build: the count is unchanged.
    - Single build: the new byte is stored and `pending` stays 1.
- Pop when empty: no effect; `pending` stays 0.
- Reset asserted mid-read or mid-ACK: everything returns to reset values immediately. A read still in progress after release is not popped, because its active phase was not seen.

## Timing
- Write at edge N → `pending` and `z80_dout` valid after edge N. The Z80 sees them on the next `z80_ce`.
- Pop detected at edge M → head, `pending` and count update after edge M.
- `SNDON` rise first sampled at edge N → `z80_nINT` low after edge N.
- Acknowledge sampled at a `z80_ce` edge → `z80_nINT` high after that same edge.
- All outputs are registered, except `z80_dout`, which is a mux of storage registers.

## Configuration
- `SNDLATCH_FIFO_EN` defined:
    - 2^`DEPTH_LOG2`-entry circular FIFO with wrap-around read/write pointers and a count.
    - `pending` = count≠0.
    - A write when full is dropped: contents are unchanged and `overrun` is set.
- Undefined:
    - Single 8-bit register; each write overwrites it. `DEPTH_LOG2` is ignored.
    - A pop clears `pending` but keeps the data.
    - A write while `pending`=1 (and not popped in the same cycle) sets `overrun`.

## Test plan
- Reset: after `nRESET` release, `z80_dout`=0x00, `z80_nINT`=1, `pending`=0, `overrun`=0.
- Write then read: write 0x3C (`SNDDT` held low 5 cycles), then one Z80 read cycle.
    - Response: exactly one write; `z80_dout`=0x3C throughout the read; `pending` falls after `z80_nRD` rises.
- FIFO build: write 0x01, 0x02, 0x03, 0x04, then 0x05.
    - Response: `overrun`=1; four reads return 0x01–0x04; a fifth read keeps `z80_dout`=0x04 with `pending`=0.
- Single build: write 0xAA then 0x55 with no read.
    - Response: `overrun`=1; the read returns 0x55.
- IRQ: raise `SNDON` → `z80_nINT` falls. Raise it again during REQ → no extra interrupt. Run the M1/IORQ acknowledge with a `SNDON` edge during ACK.
    - Response: `z80_nINT` goes high, then low again after `z80_nIORQ` rises.
- Asynchronous reset mid-read: assert `nRESET` during a read with `pending`=1.
    - Response: outputs go to reset values without waiting for a clock; no pop occurs after release.
